adder_32b: RTL and testbench

//   Registered two-operand 32-bit integer adder for the filter processor datapath.
//   - Adds opA and opB, reporting carry-out and signed overflow alongside the sum.
//   - One pipeline stage between operand capture and result.
//   - Used for accumulate/combine steps.

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_comb.sv | 24 ++
 rtl/adder_32b.sv | 86 ++++++++
 tb/tb_adder_32b.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared width, word type and signed-saturation limits for the filter datapath adder.
package adder_pkg;

    localparam int unsigned ADD_WIDTH = 32;

    typedef logic [ADD_WIDTH-1:0] word_t;

    localparam word_t SAT_MAX = 32'h7FFF_FFFF;
    localparam word_t SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/adder_comb.sv
// Purely combinational WIDTH-bit adder with unsigned carry-out and signed overflow.
module adder_comb
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    logic [WIDTH:0] s_full;

    always_comb begin
        s_full = {1'b0, a} + {1'b0, b};
        s      = s_full[WIDTH-1:0];
        co     = s_full[WIDTH];
        // Signed overflow: like-signed operands producing a result of the other sign.
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (s_full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/adder_32b.sv
// Registered two-operand adder, one cycle latency, throughput one pair per clock.
// Define ADDER_SAT_EN to signed-saturate the sum on overflow (carry/overflow stay unsaturated).
module adder_32b
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] raw_sum;
    logic             raw_co;
    logic             raw_ovf;
    logic [WIDTH-1:0] res_sum;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;

    adder_comb #(
        .WIDTH (WIDTH)
    ) u_adder_comb (
        .a   (opA),
        .b   (opB),
        .s   (raw_sum),
        .co  (raw_co),
        .ovf (raw_ovf)
    );

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

    // Operand sign tells the overflow direction: positive operands clip high.
    always_comb begin
        res_sum = raw_sum;
        if (raw_ovf) begin
            res_sum = opA[WIDTH-1] ? SatMin : SatMax;
        end
    end
`else
    assign res_sum = raw_sum;
`endif

    always_comb begin
        sum_d      = sum_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (in_valid) begin
            sum_d      = res_sum;
            carry_d    = raw_co;
            overflow_d = raw_ovf;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_32b.sv
// Directed-vector bench for adder_32b; expectations follow ADDER_SAT_EN when defined.
module tb_adder_32b;
    import adder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] sum;
    logic        carry;
    logic        overflow;
    logic        out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    adder_32b u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opA       (opA),
        .opB       (opB),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        opA      = a;
        opB      = b;
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_sum, input logic e_c,
                             input logic e_o, input logic e_v);
        check_val({tag, ".sum"}, sum, e_sum);
        check_val({tag, ".carry"}, {31'd0, carry}, {31'd0, e_c});
        check_val({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_o});
        check_val({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e_v});
    endtask

    logic [31:0] exp_pos_ovf;
    logic [31:0] exp_neg_ovf;

    initial begin
`ifdef ADDER_SAT_EN
        exp_pos_ovf = SAT_MAX;
        exp_neg_ovf = SAT_MIN;
`else
        exp_pos_ovf = 32'h8000_0000;
        exp_neg_ovf = 32'h0000_0000;
`endif
        // Reset held two cycles with a valid pair presented.
        rst_n = 1'b0;
        drive(1'b1, 32'd5, 32'd7);
        step();
        check_out("rst1", 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("rst2", 32'd0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        drive(1'b1, 32'd0, 32'd0);
        step();
        check_out("zero", 32'd0, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 32'hFFFF_FFFF, 32'd1);
        step();
        check_out("ones_p1", 32'd0, 1'b1, 1'b0, 1'b1);

        drive(1'b1, 32'h7FFF_FFFF, 32'd1);
        step();
        check_out("pos_ovf", exp_pos_ovf, 1'b0, 1'b1, 1'b1);

        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        check_out("neg1_neg1", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);

        drive(1'b1, 32'h8000_0000, 32'h8000_0000);
        step();
        check_out("neg_ovf", exp_neg_ovf, 1'b1, 1'b1, 1'b1);

        // Idle cycle: flags and sum must hold, valid drops.
        drive(1'b0, 32'd9, 32'd9);
        step();
        check_out("hold_flags", exp_neg_ovf, 1'b1, 1'b1, 1'b0);

        drive(1'b1, 32'd1, 32'd2);
        step();
        check_out("b2b_1", 32'd3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'd3, 32'd4);
        step();
        check_out("b2b_2", 32'd7, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'd10, 32'd20);
        step();
        check_out("b2b_3", 32'd30, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd50, 32'd60);
        step();
        check_out("idle1", 32'd30, 1'b0, 1'b0, 1'b0);
        step();
        check_out("idle2", 32'd30, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset discards the pair presented alongside it.
        drive(1'b1, 32'd5, 32'd6);
        step();
        check_out("pre_rst", 32'd11, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 32'd7, 32'd8);
        step();
        check_out("mid_rst", 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 32'd100, 32'd200);
        step();
        check_out("post_rst", 32'd300, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 32'd0);
        step();
        check_out("post_idle", 32'd300, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
